// File: rtl/serial_mag_cmp_pkg.sv
// rtl/serial_mag_cmp_pkg.sv - shared state encoding and sizing helper for serial_mag_cmp
package serial_mag_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_cmp_slice.sv
// rtl/bit_cmp_slice.sv - combinational one-bit equal/greater cascade stage
module bit_cmp_slice (
    input  logic a1,
    input  logic b1,
    input  logic e0,
    input  logic g0,
    output logic e1,
    output logic g1
);

    logic same;

    assign same = a1 ~^ b1;
    assign e1   = e0 & same;
    // A differing bit decides; an equal bit passes the earlier verdict through.
    assign g1   = (a1 & ~b1) | (same & g0);

endmodule

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - bit-serial unsigned magnitude comparator; SERIAL_MAG_CMP_EARLY_EXIT_EN selects MSB-first early exit
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             e;
    logic             g;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;
    logic             x;
    logic             y;
    logic             e1;
    logic             g1;
    logic             last_bit;
    logic             accept;

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
    assign x        = sa[WIDTH-1];
    assign y        = sb[WIDTH-1];
    // Higher bits were all equal, so the first difference settles the result.
    assign last_bit = (cnt == CW'(WIDTH - 1)) || (x != y);
`else
    assign x        = sa[0];
    assign y        = sb[0];
    assign last_bit = (cnt == CW'(WIDTH - 1));
`endif

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    bit_cmp_slice u_slice (
        .a1 (x),
        .b1 (y),
        .e0 (e),
        .g0 (g),
        .e1 (e1),
        .g1 (g1)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nx = ST_DONE;
            ST_DONE:  state_nx = start ? ST_SHIFT : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
            e    <= 1'b0;
            g    <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            cnt <= '0;
            e   <= 1'b1;
            g   <= 1'b0;
        end else if (state == ST_SHIFT) begin
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
            sa <= {sa[WIDTH-2:0], 1'b0};
            sb <= {sb[WIDTH-2:0], 1'b0};
`else
            sa <= {1'b0, sa[WIDTH-1:1]};
            sb <= {1'b0, sb[WIDTH-1:1]};
`endif
            cnt <= cnt + CW'(1);
            e   <= e1;
            g   <= g1;
            if (last_bit) begin
                eq_q <= e1;
                gt_q <= g1;
                lt_q <= ~e1 & ~g1;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Bit-serial unsigned magnitude comparator. It loads two WIDTH-bit operands on a start request and walks them one bit per clock through a single one-bit compare/cascade slice, holding the equal/greater cascade in flops between cycles. It reports registered eq/gt/lt with a one-cycle done pulse. It is the sequential driver for the one-bit comparator slice: it replaces a WIDTH-deep combinational slice chain when area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request to compare a and b; sampled only when idle or in the done cycle
- a  input  WIDTH  operand A, unsigned, captured on the accepting edge
- b  input  WIDTH  operand B, unsigned, captured on the accepting edge
- busy  output  1  compare in progress
- done  output  1  one-cycle pulse; results are valid from this cycle onward
- eq  output  1  a == b
- gt  output  1  a > b
- lt  output  1  a < b

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per cycle.
  - DONE: done=1 for one cycle, then returns to IDLE.
- Accept: start=1 in IDLE or DONE loads the following, sets busy=1, and enters SHIFT:
  - shift registers sa=a, sb=b
  - bit counter = 0
  - cascade e=1, g=0
- Cascade update per SHIFT cycle, with bits x from sa and y from sb:
  - e <= e & (x ~^ y)
  - g <= (x & ~y) | ((x ~^ y) & g)
- Bit order without the macro: LSB-first. Each cycle consumes bit 0 and shifts sa/sb right. A later, more significant bit dominates the earlier result.
- Leaving SHIFT: after WIDTH bits, move to DONE and latch the outputs:
  - eq = e
  - gt = g
  - lt = ~e & ~g
  - busy = 0
- Result hold: eq/gt/lt keep their values until the next accepted start. They do not clear on accept; only a new done cycle updates them.
- Exactly one of eq/gt/lt is 1 after the first done. All three are 0 after reset until then.
- start while busy=1 is ignored. Operand changes during SHIFT have no effect.
- Counter width: $clog2(WIDTH+1).

## Timing
- Reset values: busy=0, done=0, eq=0, gt=0, lt=0; state=IDLE; shift registers, counter and cascade all cleared.
- rst_n low mid-operation: aborts on that edge. The outputs take their reset values on the next cycle and no done pulse follows.
- Latency without the macro: the start is accepted at edge 0. Edges 1..WIDTH consume the bits. done=1 and the results are valid in the cycle after edge WIDTH.
- done is high for exactly one cycle per accepted start.
- busy is high from after edge 0 through the cycle before done.
- Back-to-back: start=1 in the DONE cycle is accepted on the next edge. The throughput is one compare per WIDTH+1 cycles.

## Configuration
- SERIAL_MAG_CMP_EARLY_EXIT_EN defined:
  - Bits are consumed MSB-first, shifting left.
  - The block goes to DONE on the edge that consumes the first differing bit. That bit sets gt=x&~y, lt=~x&y, eq=0.
  - If all bits are equal, it finishes after WIDTH bits with eq=1.
  - Latency = (WIDTH-1 - index of the most significant differing bit) + 1 edges after the accepting edge. The worst case is WIDTH.
- Not defined: LSB-first with fixed WIDTH-cycle latency, as described above.
- All other behaviour (reset, handshake, result hold, ignore-while-busy) is identical in both builds.

## Structure
- Shared package serial_mag_cmp_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the counter-width helper function
- Sub-module bit_cmp_slice: purely combinational one-bit cascade stage.
  - Inputs: a1, b1, e0, g0. Outputs: e1, g1.
  - Implements the update equations above.
  - Instantiated once; its outputs feed the e/g flops.
- FSM, counter and shift registers stay in serial_mag_cmp.

## Test plan
- WIDTH=8, a=8'h5A, b=8'h5A, start pulse -> done 8 edges after accept; eq=1, gt=0, lt=0; busy high for 8 cycles before done.
- a=8'h80, b=8'h7F -> gt=1, eq=0, lt=0.
  - Without the macro: done at edge 8.
  - With the macro: done at edge 1.
- a=8'h01, b=8'h02 -> lt=1.
  - Without the macro: done at edge 8.
  - With the macro: done at edge 7.
- Accept a=8'h10, b=8'h20. At edge 3 assert start with a=8'hFF, b=8'h00 -> ignored; the single done shows lt=1.
- Start a=8'hF0, b=8'h0F, then drive rst_n=0 for one edge at edge 4 -> next cycle busy=0, done=0, eq=gt=lt=0; no done pulse for 20 cycles.
- Compare 8'h33 vs 8'h33, then hold start=1 with a=8'h34, b=8'h33 in the DONE cycle -> second compare accepted; eq stays 1 until the second done, which shows gt=1.
